mult_div_ctrl: RTL and testbench

Multi-cycle multiply/divide controller owning the HI/LO register pair of the MIPS core. Sits beside the EX stage: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the issuing instruction, runs a one-bit-per-cycle shift-add multiply or restoring divide, and exposes HI/LO for MFHI/MFLO. Raises a stall toward the pipeline while an operation is in flight and any HI/LO instruction is presented.

---
 rtl/mult_div_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// HI/LO owner for the MIPS core: iterative shift-add multiply and restoring divide,
// one bit per cycle, with MTHI/MTLO writes and a pipeline stall while busy.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [1:0]       dbg_state
);

  // MFHI/MFLO need no action here; the pipeline reads Hi/Lo directly.
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;

  logic                 accept;
  logic                 is_mul_op;
  logic                 is_div_op;
  logic                 signed_op;
  logic                 last_iter;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  logic [WIDTH:0]       sum;
  logic                 ge;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  assign accept    = Start && (state == S_IDLE);
  assign is_mul_op = (Funct == F_MULT) || (Funct == F_MULTU);
  assign is_div_op = (Funct == F_DIV)  || (Funct == F_DIVU);
  assign signed_op = (Funct == F_MULT) || (Funct == F_DIV);
  assign a_mag     = (signed_op && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
  assign b_mag     = (signed_op && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;
  assign last_iter = (count == CW'(WIDTH - 1));
  assign Stall     = Busy & Start;
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (Start && is_mul_op)      state_next = S_MUL;
        else if (Start && is_div_op) state_next = S_DIV;
      end
      S_MUL, S_DIV: if (last_iter) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // acc is {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    ge       = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
    rem_new  = ge ? (acc[2*WIDTH-2:WIDTH-1] - opnd) : acc[2*WIDTH-2:WIDTH-1];
    acc_step = is_div ? {rem_new, acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi   = is_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = is_div ? quot_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && (is_mul_op || is_div_op)) begin
            count   <= '0;
            is_div  <= is_div_op;
            neg_res <= signed_op && (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
            neg_rem <= signed_op && Rdata1[WIDTH-1];
            if (is_div_op) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO change only on a finished result or an idle MTHI/MTLO.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Hi   <= '0;
      Lo   <= '0;
      Done <= 1'b0;
    end else begin
      Done <= (state == S_FIX);
      if (state == S_FIX) begin
        Hi <= fix_hi;
        Lo <= fix_lo;
      end else if (accept && (Funct == F_MTHI)) begin
        Hi <= Rdata1;
      end else if (accept && (Funct == F_MTLO)) begin
        Lo <= Rdata1;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: latency, arithmetic corner cases, stall,
// MTHI/MTLO, back-to-back issue and asynchronous reset mid-operation.
module tb_mult_div_ctrl;
  localparam int W = 32;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic         CLK, RST, Start;
  logic [5:0]   Funct;
  logic [W-1:0] Rdata1, Rdata2, Hi, Lo;
  logic         Busy, Stall, Done;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Funct(Funct),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .Stall(Stall), .Done(Done), .dbg_state(dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents the op for one cycle (cycle N); returns 1ns into cycle N+1.
  task automatic start_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    step();
    Start = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
    step();
    Start = 1'b0;
  endtask

  // Called 1ns into cycle N+1; returns at the negedge of the Done cycle, lat = cycles after N.
  task automatic wait_done(output int lat);
    lat = 1;
    forever begin
      @(negedge CLK);
      if (Done === 1'b1) break;
      if (lat >= 100) begin
        lat = -1;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; Start = 1'b0; Funct = '0; Rdata1 = '0; Rdata2 = '0;
    #12;
    n_checks++; if (Hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi: got %h want %h", Hi, 32'h0); end
    n_checks++; if (Lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo: got %h want %h", Lo, 32'h0); end
    n_checks++; if (Busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", Done); end
    n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge CLK);
    RST = 1'b1;
    step();
    Start = 1'b1; Funct = F_MFLO;
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_errors++; $display("FAIL idle_mflo_stall: got %b want 0", Stall); end
    step();
    Start = 1'b0;
    n_checks++; if (Busy !== 1'b0) begin n_errors++; $display("FAIL idle_mflo_busy: got %b want 0", Busy); end
  endtask

  task automatic test_multu_timing();
    start_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 33; k++) begin
      @(negedge CLK);
      n_checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin
        n_errors++; $display("FAIL multu_busy_window: cycle N+%0d busy=%b done=%b want 1/0", k, Busy, Done);
      end
      if (k == 1) begin
        n_checks++; if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL multu_state_mul: got %0d want 1", dbg_state); end
      end
      if (k == 33) begin
        n_checks++; if (dbg_state !== 2'd3) begin n_errors++; $display("FAIL multu_state_fix: got %0d want 3", dbg_state); end
        n_checks++; if (Hi !== 32'h0 || Lo !== 32'h0) begin
          n_errors++; $display("FAIL multu_hilo_stable: got %h_%h want 0_0", Hi, Lo);
        end
      end
      step();
    end
    @(negedge CLK);
    n_checks++; if (Done !== 1'b1 || Busy !== 1'b0) begin
      n_errors++; $display("FAIL multu_done_n34: done=%b busy=%b want 1/0", Done, Busy);
    end
    n_checks++; if (Hi !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL multu_hi: got %h want %h", Hi, 32'hFFFF_FFFE); end
    n_checks++; if (Lo !== 32'h0000_0001) begin n_errors++; $display("FAIL multu_lo: got %h want %h", Lo, 32'h1); end
    step();
    @(negedge CLK);
    n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL multu_done_pulse: got %b want 0", Done); end
  endtask

  task automatic test_mult_signed();
    int lat;
    start_op(F_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat);
    n_checks++; if (lat !== 34) begin n_errors++; $display("FAIL mult_neg_latency: got %0d want 34", lat); end
    n_checks++; if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFF1) begin
      n_errors++; $display("FAIL mult_neg: got %h_%h want ffffffff_fffffff1", Hi, Lo);
    end
    start_op(F_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat);
    n_checks++; if (lat !== 34 || Hi !== 32'h4000_0000 || Lo !== 32'h0) begin
      n_errors++; $display("FAIL mult_minint: lat=%0d got %h_%h want 34 40000000_00000000", lat, Hi, Lo);
    end
  endtask

  task automatic test_divide();
    int lat;
    start_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    n_checks++; if (lat !== 34 || Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin
      n_errors++; $display("FAIL div_neg7_2: lat=%0d lo=%h hi=%h want 34 fffffffd ffffffff", lat, Lo, Hi);
    end
    start_op(F_DIVU, 32'd100, 32'd7);
    wait_done(lat);
    n_checks++; if (Lo !== 32'd14 || Hi !== 32'd2) begin
      n_errors++; $display("FAIL divu_100_7: lo=%h hi=%h want 0000000e 00000002", Lo, Hi);
    end
    start_op(F_DIVU, 32'd5, 32'd0);
    wait_done(lat);
    n_checks++; if (Lo !== 32'hFFFF_FFFF || Hi !== 32'd5) begin
      n_errors++; $display("FAIL divu_by_zero: lo=%h hi=%h want ffffffff 00000005", Lo, Hi);
    end
    start_op(F_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(lat);
    n_checks++; if (Lo !== 32'h1 || Hi !== 32'hFFFF_FFF9) begin
      n_errors++; $display("FAIL div_neg_by_zero: lo=%h hi=%h want 00000001 fffffff9", Lo, Hi);
    end
    start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    n_checks++; if (Lo !== 32'h8000_0000 || Hi !== 32'h0) begin
      n_errors++; $display("FAIL div_minint_m1: lo=%h hi=%h want 80000000 00000000", Lo, Hi);
    end
  endtask

  task automatic test_stall();
    start_op(F_MULT, 32'd7, 32'd6);
    Start = 1'b1; Funct = F_MFLO;
    for (int k = 1; k <= 33; k++) begin
      @(negedge CLK);
      n_checks++; if (Stall !== 1'b1) begin n_errors++; $display("FAIL stall_mflo: cycle N+%0d got %b want 1", k, Stall); end
      step();
    end
    @(negedge CLK);
    n_checks++; if (Stall !== 1'b0 || Done !== 1'b1 || Lo !== 32'd42) begin
      n_errors++; $display("FAIL stall_release: stall=%b done=%b lo=%h want 0 1 0000002a", Stall, Done, Lo);
    end
    step();
    Start = 1'b0;
    start_op(F_MULT, 32'd2, 32'd3);
    Start = 1'b1; Funct = F_MTLO; Rdata1 = 32'h1234;
    for (int k = 1; k <= 33; k++) begin
      @(negedge CLK);
      if (k == 2) begin
        n_checks++; if (Lo !== 32'd42) begin n_errors++; $display("FAIL mtlo_while_busy: lo=%h want 0000002a", Lo); end
      end
      step();
    end
    @(negedge CLK);
    n_checks++; if (Stall !== 1'b0 || Lo !== 32'd6) begin
      n_errors++; $display("FAIL mtlo_hold_result: stall=%b lo=%h want 0 00000006", Stall, Lo);
    end
    step();
    Start = 1'b0;
    @(negedge CLK);
    n_checks++; if (Lo !== 32'h1234 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_errors++; $display("FAIL mtlo_after_idle: lo=%h busy=%b done=%b want 00001234 0 0", Lo, Busy, Done);
    end
  endtask

  task automatic test_mthi();
    step();
    Start = 1'b1; Funct = F_MTHI; Rdata1 = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_errors++; $display("FAIL mthi_stall: got %b want 0", Stall); end
    step();
    Start = 1'b0;
    @(negedge CLK);
    n_checks++; if (Hi !== 32'hDEAD_BEEF || Busy !== 1'b0 || Done !== 1'b0) begin
      n_errors++; $display("FAIL mthi_write: hi=%h busy=%b done=%b want deadbeef 0 0", Hi, Busy, Done);
    end
    n_checks++; if (Lo !== 32'h1234) begin n_errors++; $display("FAIL mthi_lo_untouched: lo=%h want 00001234", Lo); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(F_DIVU, 32'd100, 32'd7);
    wait_done(lat);
    Start = 1'b1; Funct = F_MULTU; Rdata1 = 32'h0001_0000; Rdata2 = 32'h0001_0000;
    #1;
    n_checks++; if (Stall !== 1'b0 || Done !== 1'b1) begin
      n_errors++; $display("FAIL b2b_accept: stall=%b done=%b want 0 1", Stall, Done);
    end
    step();
    Start = 1'b0;
    n_checks++; if (Busy !== 1'b1 || Done !== 1'b0 || Lo !== 32'd14 || Hi !== 32'd2) begin
      n_errors++; $display("FAIL b2b_second_busy: busy=%b done=%b lo=%h hi=%h want 1 0 0000000e 00000002", Busy, Done, Lo, Hi);
    end
    wait_done(lat);
    n_checks++; if (lat !== 34 || Hi !== 32'h1 || Lo !== 32'h0) begin
      n_errors++; $display("FAIL b2b_second_result: lat=%0d hi=%h lo=%h want 34 00000001 00000000", lat, Hi, Lo);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    step();
    Start = 1'b1; Funct = F_MTHI; Rdata1 = 32'h1111_1111;
    step();
    Funct = F_MTLO; Rdata1 = 32'h2222_2222;
    step();
    Start = 1'b0;
    @(negedge CLK);
    n_checks++; if (Hi !== 32'h1111_1111 || Lo !== 32'h2222_2222) begin
      n_errors++; $display("FAIL preload: hi=%h lo=%h want 11111111 22222222", Hi, Lo);
    end
    start_op(F_DIVU, 32'd1000, 32'd3);
    for (int k = 0; k < 10; k++) step();
    #2;
    RST = 1'b0;
    #1;
    n_checks++; if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0 || dbg_state !== 2'd0) begin
      n_errors++; $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b state=%0d want 0 0 0 0 0", Hi, Lo, Busy, Done, dbg_state);
    end
    @(negedge CLK);
    RST = 1'b1;
    start_op(F_MULTU, 32'd3, 32'd4);
    wait_done(lat);
    n_checks++; if (lat !== 34 || Lo !== 32'd12 || Hi !== 32'h0) begin
      n_errors++; $display("FAIL post_reset_multu: lat=%0d lo=%h hi=%h want 34 0000000c 00000000", lat, Lo, Hi);
    end
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_mult_signed();
    test_divide();
    test_stall();
    test_mthi();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
